// File: rtl/frame_fetch_pkg.sv
// frame_fetch_pkg: shared widths, FSM states, reset defaults and address stepping for frame_fetch
package frame_fetch_pkg;
  localparam int ADDR_W = 25;
  localparam int LEN_W = 10;
  localparam int DATA_W = 32;
  localparam int ADDR_STEP_SHIFT = 3;
  typedef enum logic [2:0] {IDLE, WAIT_SPACE, REQ, DATA, DRAIN} state_e;
  localparam state_e RST_STATE = IDLE;
  localparam logic RST_FLAG = 1'b0;
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] len);
    return a + ((ADDR_W)'(len) << ADDR_STEP_SHIFT);
  endfunction
endpackage

// File: rtl/frame_fetch_if.sv
// frame_fetch_if: read-request and return-data bus between frame_fetch and ddr2_mgr
interface frame_fetch_if;
  logic rd_mem_req;
  logic [frame_fetch_pkg::ADDR_W-1:0] rd_mem_addr;
  logic [frame_fetch_pkg::LEN_W-1:0] rd_xfr_len;
  logic rd_mem_grant;
  logic [frame_fetch_pkg::DATA_W-1:0] rd_data;
  logic rd_data_valid;
  modport master (output rd_mem_req, rd_mem_addr, rd_xfr_len, input rd_mem_grant, rd_data, rd_data_valid);
  modport slave (input rd_mem_req, rd_mem_addr, rd_xfr_len, output rd_mem_grant, rd_data, rd_data_valid);
endinterface

// File: rtl/frame_fetch_fifo.sv
// frame_fetch_fifo: single-clock FIFO with flush; head and flags come straight from registers
module frame_fetch_fifo #(
  parameter int AW = 10
) (
  input logic clk0,
  input logic rst0_n,
  input logic flush,
  input logic push,
  input logic pop,
  input logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [AW:0] count,
  output logic full,
  output logic empty
);
  logic [31:0] mem [2**AW];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(2 ** AW);
  assign empty = count == '0;
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign rdata = empty ? '0 : mem[rp];
  // storage needs no reset: the head is masked while empty
  always_ff @(posedge clk0)
    if (do_push) mem[wp] <= wdata;
  // pointers and occupancy; a flush wins over any same-cycle push or pop
  always_ff @(posedge clk0 or negedge rst0_n)
    if (!rst0_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + (AW)'(do_push);
      rp <= rp + (AW)'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/frame_fetch.sv
// frame_fetch: walks one frame in fixed bursts from ddr2_mgr into a pop-on-demand pixel FIFO
module frame_fetch
  import frame_fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] FRAME_BASE = '0,
  parameter logic [LEN_W-1:0] XFR_LEN = 10'h200,
  parameter logic [15:0] REQS_PER_FRAME = 16'd600,
  parameter int FIFO_AW = 10
) (
  input logic clk0,
  input logic rst0_n,
  frame_fetch_if.master mem,
  input logic frame_start,
  input logic pix_rd_en,
  output logic [DATA_W-1:0] pix_data,
  output logic pix_empty,
  output logic fetch_busy,
  output logic underflow,
  output logic stray_beat
);
  localparam int DEPTH = 2 ** FIFO_AW;
  state_e state, nxt;
  logic [ADDR_W-1:0] addr;
  logic [15:0] req_cnt;
  logic [LEN_W-1:0] beat_cnt;
  logic [FIFO_AW:0] fifo_count;
  logic fifo_full, pop_ok, space_ok, last_beat, restart, burst_done, req_d, busy_d, push, stray_set;
  assign pop_ok = pix_rd_en & ~pix_empty;
  assign space_ok = DEPTH - int'(fifo_count) + int'(pop_ok) >= int'(XFR_LEN);
  assign last_beat = mem.rd_data_valid && beat_cnt == XFR_LEN - (LEN_W)'(1);
  assign mem.rd_mem_addr = addr;
  assign mem.rd_xfr_len = XFR_LEN;
  // state register
  always_ff @(posedge clk0 or negedge rst0_n)
    if (!rst0_n) state <= RST_STATE;
    else state <= nxt;
  // next state; restart is the flush/rewind action, burst_done advances the frame walk
  always_comb begin
    nxt = state;
    restart = 1'b0;
    burst_done = 1'b0;
    unique case (state)
      IDLE: if (frame_start) begin
        restart = 1'b1;
        nxt = WAIT_SPACE;
      end
      WAIT_SPACE: if (frame_start) restart = 1'b1;
        else if (space_ok) nxt = REQ;
      REQ: if (mem.rd_mem_grant) nxt = frame_start ? DRAIN : DATA;
        else if (frame_start) begin
          restart = 1'b1;
          nxt = WAIT_SPACE;
        end
      DATA: if (frame_start) nxt = DRAIN;
        else if (last_beat) begin
          burst_done = 1'b1;
          nxt = req_cnt + 16'd1 == REQS_PER_FRAME ? IDLE : WAIT_SPACE;
        end
      DRAIN: if (beat_cnt == XFR_LEN || last_beat) begin
        restart = 1'b1;
        nxt = WAIT_SPACE;
      end
      default: nxt = IDLE;
    endcase
  end
  // outputs: request/busy are registered from the next state; beats only land in the FIFO during DATA
  always_comb begin
    req_d = nxt == REQ;
    busy_d = nxt != IDLE;
    push = state == DATA && mem.rd_data_valid && !fifo_full;
    stray_set = mem.rd_data_valid && (state == IDLE || state == WAIT_SPACE || state == REQ);
  end
  // address walk, counters and sticky error flags (a new error beats a same-cycle clear)
  always_ff @(posedge clk0 or negedge rst0_n)
    if (!rst0_n) begin
      addr <= FRAME_BASE;
      req_cnt <= '0;
      beat_cnt <= '0;
      mem.rd_mem_req <= RST_FLAG;
      fetch_busy <= RST_FLAG;
      underflow <= RST_FLAG;
      stray_beat <= RST_FLAG;
    end else begin
      mem.rd_mem_req <= req_d;
      fetch_busy <= busy_d;
      underflow <= (underflow & ~restart) | (pix_rd_en & pix_empty);
      stray_beat <= (stray_beat & ~restart) | stray_set;
      if (restart) begin
        addr <= FRAME_BASE;
        req_cnt <= '0;
      end else if (burst_done) begin
        addr <= next_addr(addr, XFR_LEN);
        req_cnt <= req_cnt + 16'd1;
      end
      if (state == REQ && mem.rd_mem_grant) beat_cnt <= '0;
      else if (mem.rd_data_valid && (state == DATA || state == DRAIN) && beat_cnt != XFR_LEN)
        beat_cnt <= beat_cnt + (LEN_W)'(1);
    end
  frame_fetch_fifo #(.AW(FIFO_AW)) u_fifo (
    .clk0(clk0),
    .rst0_n(rst0_n),
    .flush(restart),
    .push(push),
    .pop(pix_rd_en),
    .wdata(mem.rd_data),
    .rdata(pix_data),
    .count(fifo_count),
    .full(fifo_full),
    .empty(pix_empty)
  );
endmodule

// File: tb/tb_frame_fetch.sv
// tb_frame_fetch: drives ddr2_mgr-side handshakes and checks frame_fetch against a queue model
module tb_frame_fetch;
  localparam logic [24:0] BASE = 25'h1FFFFE0;
  logic clk0 = 1'b0;
  logic rst0_n, frame_start, pix_rd_en;
  logic [31:0] pix_data;
  logic pix_empty, fetch_busy, underflow, stray_beat;
  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] q[$];
  logic uf_exp = 1'b0;
  logic st_exp = 1'b0;
  typedef struct {
    int pop_pct;
    logic [24:0] addr;
    logic busy_after;
  } vec_t;
  vec_t tbl[3];
  frame_fetch_if mif();
  frame_fetch #(.FRAME_BASE(BASE), .XFR_LEN(10'd4), .REQS_PER_FRAME(16'd3), .FIFO_AW(3)) dut (
    .clk0(clk0),
    .rst0_n(rst0_n),
    .mem(mif),
    .frame_start(frame_start),
    .pix_rd_en(pix_rd_en),
    .pix_data(pix_data),
    .pix_empty(pix_empty),
    .fetch_busy(fetch_busy),
    .underflow(underflow),
    .stray_beat(stray_beat)
  );
  always #5 clk0 = ~clk0;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic pr(input int p);
    return $urandom_range(99) < p;
  endfunction
  // one clock: pre-edge pop check against model head, post-edge model update and flag checks
  task automatic cyc(input logic v, input logic [31:0] d, input logic pop, input logic acc, input logic fl);
    logic ufn;
    mif.rd_data_valid = v;
    mif.rd_data = d;
    pix_rd_en = pop;
    ufn = pop && q.size() == 0;
    if (pop && q.size() > 0) begin
      chk("pop_data", pix_data, q[0]);
      void'(q.pop_front());
    end
    @(posedge clk0);
    #1;
    if (fl) begin
      q.delete();
      uf_exp = 1'b0;
      st_exp = 1'b0;
    end
    if (v && acc) q.push_back(d);
    if (ufn) uf_exp = 1'b1;
    mif.rd_data_valid = 1'b0;
    mif.rd_mem_grant = 1'b0;
    pix_rd_en = 1'b0;
    frame_start = 1'b0;
    chk("pix_empty", pix_empty, q.size() == 0);
    chk("underflow", underflow, uf_exp);
    chk("stray_beat", stray_beat, st_exp);
  endtask
  task automatic wait_req(input int pp);
    int n = 0;
    while (!mif.rd_mem_req && n < 200) begin
      cyc(1'b0, '0, pr(pp), 1'b0, 1'b0);
      n++;
    end
    chk("req_seen", mif.rd_mem_req, 1'b1);
  endtask
  task automatic serve(input logic [24:0] ea, input int pp);
    wait_req(pp);
    chk("req_addr", mif.rd_mem_addr, ea);
    mif.rd_mem_grant = 1'b1;
    cyc(1'b0, '0, pr(pp), 1'b0, 1'b0);
    chk("req_drop", mif.rd_mem_req, 1'b0);
    for (int b = 0; b < 4; b++) begin
      repeat ($urandom_range(2)) cyc(1'b0, '0, pr(pp), 1'b0, 1'b0);
      cyc(1'b1, $urandom, pr(pp), 1'b1, 1'b0);
    end
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 100) begin
      cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
      n++;
    end
  endtask
  task automatic run_frame();
    for (int i = 0; i < 3; i++) begin
      serve(tbl[i].addr, tbl[i].pop_pct);
      chk("busy_after_burst", fetch_busy, tbl[i].busy_after);
    end
    drain();
  endtask
  initial begin
    tbl[0] = '{pop_pct: 50, addr: 25'h1FFFFE0, busy_after: 1'b1};
    tbl[1] = '{pop_pct: 30, addr: 25'h0000000, busy_after: 1'b1};
    tbl[2] = '{pop_pct: 70, addr: 25'h0000020, busy_after: 1'b0};
    rst0_n = 1'b0;
    frame_start = 1'b0;
    pix_rd_en = 1'b0;
    mif.rd_mem_grant = 1'b0;
    mif.rd_data = '0;
    mif.rd_data_valid = 1'b0;
    repeat (3) @(posedge clk0);
    #1 rst0_n = 1'b1;
    chk("rst_req", mif.rd_mem_req, 1'b0);
    chk("rst_addr", mif.rd_mem_addr, BASE);
    chk("rst_xfr_len", mif.rd_xfr_len, 10'd4);
    chk("rst_empty", pix_empty, 1'b1);
    chk("rst_data", pix_data, 32'h0);
    chk("rst_busy", fetch_busy, 1'b0);
    chk("rst_underflow", underflow, 1'b0);
    chk("rst_stray", stray_beat, 1'b0);
    // frame start latency, then a full frame with address wrap and random pops
    frame_start = 1'b1;
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("lat_busy", fetch_busy, 1'b1);
    chk("lat_req_early", mif.rd_mem_req, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("lat_req", mif.rd_mem_req, 1'b1);
    run_frame();
    // backpressure: third request held until four words are popped; stray beat in WAIT_SPACE
    frame_start = 1'b1;
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    serve(25'h1FFFFE0, 0);
    serve(25'h0000000, 0);
    repeat (5) begin
      cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
      chk("bp_withheld", mif.rd_mem_req, 1'b0);
    end
    st_exp = 1'b1;
    cyc(1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
    chk("stray_no_req", mif.rd_mem_req, 1'b0);
    repeat (3) begin
      cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
      chk("bp_still_held", mif.rd_mem_req, 1'b0);
    end
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("bp_released", mif.rd_mem_req, 1'b1);
    serve(25'h0000020, 0);
    chk("bp_busy_end", fetch_busy, 1'b0);
    drain();
    // restart two beats into a burst: remaining beats discarded, FIFO flushed, rewind to base
    frame_start = 1'b1;
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    wait_req(0);
    chk("drain_first_addr", mif.rd_mem_addr, BASE);
    mif.rd_mem_grant = 1'b1;
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, $urandom, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, $urandom, 1'b0, 1'b1, 1'b0);
    frame_start = 1'b1;
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("drain_busy", fetch_busy, 1'b1);
    cyc(1'b1, 32'h11111111, 1'b0, 1'b0, 1'b0);
    chk("drain_no_req", mif.rd_mem_req, 1'b0);
    cyc(1'b1, 32'h22222222, 1'b0, 1'b0, 1'b1);
    chk("drain_flushed", pix_empty, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("restart_req", mif.rd_mem_req, 1'b1);
    chk("restart_addr", mif.rd_mem_addr, BASE);
    // frame_start while requesting but not granted aborts at once
    frame_start = 1'b1;
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("abort_req", mif.rd_mem_req, 1'b0);
    chk("abort_busy", fetch_busy, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("abort_rereq", mif.rd_mem_req, 1'b1);
    run_frame();
    // underflow: sticky, leaves the FIFO pointers alone, cleared by the next frame_start
    frame_start = 1'b1;
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("uf_set", underflow, 1'b1);
    serve(25'h1FFFFE0, 0);
    repeat (2) cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    drain();
    chk("uf_held", underflow, 1'b1);
    wait_req(0);
    frame_start = 1'b1;
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("uf_cleared", underflow, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
